// File: rtl/serial_comp_unit.sv
// serial_comp_unit: LSB-first serial pass/one's/two's complementer with parallel writeback.
// Optional overflow flag on the done cycle when SERIAL_COMP_OVF_EN is defined.
module serial_comp_unit #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic             y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, next_state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0] count;
    logic [1:0] mode_q;
    logic q, so, f;
    always_ff @(posedge Clock) begin
        if (!reset_b) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        busy = 1'b0;
        done = 1'b0;
        y = 1'b0;
        so = sreg[0];
        // Two's complement: pass bits up to and including the first 1, invert the rest.
        f = mode_q == 2'b01 ? 1'b1 : mode_q == 2'b10 ? q : 1'b0;
        case (state)
            IDLE: next_state = start && !load ? SHIFT : IDLE;
            SHIFT: begin
                busy = 1'b1;
                y = so ^ f;
                next_state = count == CW'(WIDTH - 1) ? DONE : SHIFT;
            end
            DONE: begin
                done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge Clock) begin
        if (!reset_b) begin
            sreg <= '0;
            q <= 1'b0;
            count <= '0;
            mode_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sreg <= data;
                    end else if (start) begin
                        mode_q <= mode;
                        q <= 1'b0;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    sreg <= {y, sreg[WIDTH-1:1]};
                    q <= q | so;
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end
    assign result = sreg;
`ifdef SERIAL_COMP_OVF_EN
    logic in_msb;
    always_ff @(posedge Clock) begin
        if (!reset_b) in_msb <= 1'b0;
        else if (state == IDLE && start && !load) in_msb <= sreg[WIDTH-1];
    end
    assign ovf = state == DONE && mode_q == 2'b10 && in_msb && sreg[WIDTH-1];
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: doc/serial_comp_unit.md
Name: serial_comp_unit

Overview:
Parametrised successor to the 8-bit serial two's complementer. Loads a WIDTH-bit operand in parallel and shifts it out LSB-first, one bit per cycle, on `y`. Three modes are supported: pass-through, one's complement and two's complement. A start/busy/done handshake and a counter terminate the operation automatically. The complemented word is written back into the shift register, so the parallel result is readable when the operation completes.

Parameters:
WIDTH, 8, operand width in bits. Legal range is 2 to 64.

Ports:
Clock  input  1  rising-edge clock.
reset_b  input  1  synchronous, active-low reset.
data  input  WIDTH  parallel operand, captured on `load`.
load  input  1  capture `data` into the shift register. Honoured only in IDLE.
start  input  1  begin a WIDTH-cycle serial operation. Honoured only in IDLE.
mode  input  2  00 = pass, 01 = one's complement, 10 = two's complement, 11 = reserved (behaves as pass).
y  output  1  serial output bit, LSB first. Valid while `busy` = 1; driven 0 otherwise.
busy  output  1  high during the WIDTH shift cycles.
done  output  1  one-cycle pulse after the last shift.
result  output  WIDTH  shift-register contents. Holds the complete result from the `done` cycle until the next `load`.
ovf  output  1  two's-complement overflow flag (see Optional Feature).

Behaviour:
- All state updates on the rising edge of `Clock`. Reset is synchronous: when `reset_b` = 0 at the edge, the block clears everything:
  - SReg = 0, Q = 0, count = 0, state = IDLE, latched mode = 00, in_msb = 0.
  - Outputs: busy = 0, done = 0, y = 0, result = 0, ovf = 0.
- State machine has three states.
  - IDLE:
    - `load` = 1: SReg <= data.
    - `start` = 1 with `load` = 0: latch `mode`, in_msb <= SReg[WIDTH-1], Q <= 0, count <= 0, go to SHIFT.
    - `load` and `start` both 1: `load` wins and `start` is ignored. The bench must assert `start` on a later cycle.
  - SHIFT:
    - busy = 1.
    - SO = SReg[0].
    - y = SO ^ f, where f is:
      - 0 for pass;
      - 1 for one's complement;
      - Q for two's complement.
    - Each cycle:
      - SReg <= {y, SReg[WIDTH-1:1]};
      - Q <= Q | SO;
      - count <= count + 1.
    - When count = WIDTH-1, the shift still happens and the state goes to DONE.
    - SHIFT lasts exactly WIDTH cycles.
    - `load`, `start` and `mode` changes are ignored during SHIFT.
  - DONE:
    - done = 1 and busy = 0 for one cycle; SReg is held.
    - Next state is IDLE unconditionally. `load` and `start` are ignored in this cycle.
- Latency: a `start` accepted at edge k makes busy = 1 for cycles k+1 through k+WIDTH. `done` = 1 in cycle k+WIDTH+1. The earliest next `start` is accepted at edge k+WIDTH+2.
- The counter is $clog2(WIDTH) bits wide and never wraps during an operation.
- Two's complement of 0 gives 0, and Q stays 0 throughout.
- A reset asserted mid-SHIFT aborts the operation. No `done` pulse is produced and `result` reads 0.
- `start` in IDLE without a prior `load` operates on the current SReg contents (0 after reset, or the previous result).

Optional Feature:
Macro SERIAL_COMP_OVF_EN.
- Defined: during the DONE cycle, ovf = (latched mode == 10) & in_msb & SReg[WIDTH-1]. This is true only when negating the most-negative value (1 followed by WIDTH-1 zeros). ovf is 0 in all other cycles.
- Not defined: ovf is tied to 0 and no overflow logic is synthesised. The port is present in both builds.

Test Plan:
1. WIDTH=8, reset, load 8'h06, then start with mode=10 -> y over the busy cycles = 0,1,0,1,1,1,1,1; done pulses in the 9th cycle after start; result = 8'hFA; ovf = 0.
2. Load 8'h0F with mode=01 -> result = 8'hF0. Load 8'hA5 with mode=00 -> result = 8'hA5. Mode=11 with 8'hA5 -> result = 8'hA5.
3. Load 8'h00 with mode=10 -> y = 0 on all 8 cycles; result = 8'h00; ovf = 0.
4. Load 8'h80 with mode=10 -> result = 8'h80. ovf = 1 in the done cycle with SERIAL_COMP_OVF_EN defined, 0 without it.
5. Start on 8'h06 with mode=10; pulse load = 1 with data = 8'hFF in busy cycle 3 -> load is ignored and result = 8'hFA. Drive reset_b = 0 in busy cycle 3 of a second run -> the next cycle has busy = 0, result = 0, and no done pulse.
6. load and start asserted in the same IDLE cycle with data 8'h06 -> busy stays 0 and SReg = 8'h06. start on the following cycle with mode=10 -> result = 8'hFA. Repeat with WIDTH=16 and data 16'h0001 -> result = 16'hFFFF after 16 busy cycles.
